// File: rtl/f1_reaction_timer.sv
// f1_reaction_timer: random start-light delay followed by a driver reaction-time measurement.
// Define F1_FALSE_START_EN to report a button press during the delay as a false start.
module f1_reaction_timer #(
  parameter int CNT_WIDTH = 16,
  parameter int MIN_DELAY = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 cmd_delay,
  input  logic                 btn,
  output logic                 lights_out,
  output logic                 react_valid,
  output logic [CNT_WIDTH-1:0] react_time,
  output logic                 false_start,
  output logic                 busy
);

  // state  | meaning
  // IDLE   | waiting for a cmd_delay rising edge
  // DELAY  | counting down the random delay on en ticks
  // TIMING | lights out; counting clk cycles until the button edge
  typedef enum logic [1:0] {IDLE, DELAY, TIMING} state_t;

  localparam logic [7:0]           MIN_DELAY_8 = 8'(MIN_DELAY);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

  state_t               state;
  logic [6:0]           lfsr;
  logic [7:0]           delay_cnt;
  logic [CNT_WIDTH-1:0] react_cnt;
  logic                 cmd_q;
  logic                 btn_q;
  logic                 cmd_rise;
  logic                 btn_rise;

  assign cmd_rise = cmd_delay & ~cmd_q;
  assign btn_rise = btn & ~btn_q;
  assign busy     = (state != IDLE);

`ifdef F1_FALSE_START_EN
  logic fs_pulse;
  assign false_start = fs_pulse;
`else
  assign false_start = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lfsr        <= 7'h01;
      delay_cnt   <= 8'd0;
      react_cnt   <= '0;
      cmd_q       <= 1'b0;
      btn_q       <= 1'b0;
      lights_out  <= 1'b0;
      react_valid <= 1'b0;
      react_time  <= '0;
`ifdef F1_FALSE_START_EN
      fs_pulse    <= 1'b0;
`endif
    end else begin
      lfsr        <= {lfsr[5:0], lfsr[6] ^ lfsr[2]};
      cmd_q       <= cmd_delay;
      btn_q       <= btn;
      lights_out  <= 1'b0;
      react_valid <= 1'b0;
`ifdef F1_FALSE_START_EN
      fs_pulse    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (cmd_rise) begin
            delay_cnt <= {1'b0, lfsr} + MIN_DELAY_8;
            state     <= DELAY;
          end
        end
        DELAY: begin
`ifdef F1_FALSE_START_EN
          if (btn_rise) begin
            fs_pulse    <= 1'b1;
            react_valid <= 1'b1;
            react_time  <= '1;
            state       <= IDLE;
          end else
`endif
          if (en) begin
            if (delay_cnt != 8'd0) begin
              delay_cnt <= delay_cnt - 8'd1;
            end else begin
              react_cnt  <= '0;
              lights_out <= 1'b1;
              state      <= TIMING;
            end
          end
        end
        TIMING: begin
          // saturate rather than wrap so a very slow reaction reads as full scale
          if (react_cnt != '1) react_cnt <= react_cnt + CNT_ONE;
          if (btn_rise) begin
            react_time  <= react_cnt;
            react_valid <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_f1_reaction_timer.sv
// Randomized bench for f1_reaction_timer: two instances (16-bit and 4-bit counters) vs a timing model.
module tb_f1_reaction_timer;

  localparam int MIN_DELAY = 8;

  logic clk = 1'b0;
  logic rst, en, cmd_delay, btn;
  logic lo16, rv16, fs16, busy16;
  logic [15:0] rt16;
  logic lo4, rv4, fs4, busy4;
  logic [3:0] rt4;

  int checks = 0;
  int failures = 0;
  logic [6:0] m_lfsr;
  int exp_rt16, exp_rt4;

  always #5 clk = ~clk;

  f1_reaction_timer #(.CNT_WIDTH(16), .MIN_DELAY(MIN_DELAY)) dut (
    .clk(clk), .rst(rst), .en(en), .cmd_delay(cmd_delay), .btn(btn),
    .lights_out(lo16), .react_valid(rv16), .react_time(rt16),
    .false_start(fs16), .busy(busy16)
  );

  f1_reaction_timer #(.CNT_WIDTH(4), .MIN_DELAY(MIN_DELAY)) dut4 (
    .clk(clk), .rst(rst), .en(en), .cmd_delay(cmd_delay), .btn(btn),
    .lights_out(lo4), .react_valid(rv4), .react_time(rt4),
    .false_start(fs4), .busy(busy4)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input bit e_lo, input bit e_rv, input bit e_fs,
                            input bit e_busy);
    check_eq({tag, "_lo16"}, 32'(lo16), 32'(e_lo));
    check_eq({tag, "_rv16"}, 32'(rv16), 32'(e_rv));
    check_eq({tag, "_fs16"}, 32'(fs16), 32'(e_fs));
    check_eq({tag, "_busy16"}, 32'(busy16), 32'(e_busy));
    check_eq({tag, "_rt16"}, 32'(rt16), exp_rt16);
    check_eq({tag, "_lo4"}, 32'(lo4), 32'(e_lo));
    check_eq({tag, "_rv4"}, 32'(rv4), 32'(e_rv));
    check_eq({tag, "_fs4"}, 32'(fs4), 32'(e_fs));
    check_eq({tag, "_busy4"}, 32'(busy4), 32'(e_busy));
    check_eq({tag, "_rt4"}, 32'(rt4), exp_rt4);
  endtask

  function automatic bit rnd_pct(input int pct);
    return ($urandom_range(99) < pct);
  endfunction

  // one clock edge; the model LFSR advances with the same rule as the spec
  task automatic step();
    @(posedge clk);
    if (rst) m_lfsr = 7'h01;
    else     m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[2]};
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cmd_delay = 1'b0; btn = 1'b0; en = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    exp_rt16 = 0;
    exp_rt4 = 0;
    check_outs("reset", 0, 0, 0, 0);
  endtask

  // gap idle cycles, then a start; fs_at = DELAY cycle of an early press (-1 none);
  // k = reaction in clk cycles after lights out; rst_at = TIMING cycle to reset (-1 none)
  task automatic run_round(input int gap, input int en_pct, input int k, input int fs_at,
                           input int rst_at);
    int need, ticks, cyc;
    bit press;
    for (int i = 0; i < gap; i++) begin
      cmd_delay = 1'b0; btn = 1'(($urandom_range(1))); en = rnd_pct(en_pct);
      step();
      check_outs("idle", 0, 0, 0, 0);
    end
    cmd_delay = 1'b1;
    btn = 1'(($urandom_range(1)));
    en = rnd_pct(en_pct);
    need = int'(m_lfsr) + MIN_DELAY + 1;
    ticks = 0;
    step();
    btn = 1'b0;
    check_outs("start", 0, 0, 0, 1);

    cyc = 0;
    while (ticks < need) begin
      en = rnd_pct(en_pct);
      cmd_delay = 1'(($urandom_range(1)));
      press = (cyc == fs_at);
      btn = press;
      step();
      btn = 1'b0;
      cyc++;
`ifdef F1_FALSE_START_EN
      if (press) begin
        exp_rt16 = 32'hFFFF;
        exp_rt4 = 15;
        check_outs("false_start", 0, 1, 1, 0);
        cmd_delay = 1'b0;
        step();
        check_outs("after_fs", 0, 0, 0, 0);
        return;
      end
`endif
      if (en) ticks++;
      check_outs("delay", ticks == need, 0, 0, 1);
    end

    for (int j = 0; j < k; j++) begin
      en = rnd_pct(50);
      cmd_delay = 1'(($urandom_range(1)));
      if (j == rst_at) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_rt16 = 0;
        exp_rt4 = 0;
        check_outs("mid_rst", 0, 0, 0, 0);
        cmd_delay = 1'b0;
        step();
        check_outs("post_rst", 0, 0, 0, 0);
        return;
      end
      step();
      check_outs("timing", 0, 0, 0, 1);
    end

    btn = 1'b1;
    en = rnd_pct(50);
    cmd_delay = 1'(($urandom_range(1)));
    step();
    btn = 1'b0;
    cmd_delay = 1'b0;
    exp_rt16 = (k > 65535) ? 65535 : k;
    exp_rt4 = (k > 15) ? 15 : k;
    check_outs("react", 0, 1, 0, 0);
    step();
    check_outs("after_react", 0, 0, 0, 0);
  endtask

  initial begin
    do_reset();
    run_round(0, 100, 37, -1, -1);
    run_round(3, 100, 0, -1, -1);
    run_round(2, 60, 40, -1, -1);
    run_round(1, 100, 20, 5, -1);
    run_round(0, 50, 30, -1, 10);
    run_round(0, 100, 12, -1, -1);
    for (int r = 0; r < 15; r++) begin
      run_round($urandom_range(5), $urandom_range(100, 20), $urandom_range(300),
                rnd_pct(30) ? int'($urandom_range(30)) : -1,
                rnd_pct(15) ? int'($urandom_range(20)) : -1);
    end
    do_reset();
    run_round(0, 100, 15, -1, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/f1_reaction_timer.md
F1_REACTION_TIMER -- requirements
Module: f1_reaction_timer

Interface
REQ-001 Parameter CNT_WIDTH, default 16: width of the reaction counter and of react_time.
REQ-002 Parameter MIN_DELAY, default 8: constant added to the random delay, legal range 0..128.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 en  input  1  delay tick, one-clk pulse from the shared clock-tick divider.
REQ-006 cmd_delay  input  1  level from the start-lights FSM; high while the final light stage is held.
REQ-007 btn  input  1  driver reaction button, already synchronous to clk.
REQ-008 lights_out  output  1  one-clk pulse marking the moment the lights go out.
REQ-009 react_valid  output  1  one-clk pulse; react_time updated in the same cycle.
REQ-010 react_time  output  CNT_WIDTH  last measured reaction in clk cycles, held between results.
REQ-011 false_start  output  1  one-clk pulse on a premature button press.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 The LFSR SHALL be 7 bits, free-running every clk, next = {lfsr[5:0], lfsr[6]^lfsr[2]}, never zero.
REQ-014 The block SHALL register cmd_delay and btn and use the rising edges: input high while its registered copy is low.
REQ-015 The FSM SHALL have exactly three states: IDLE, DELAY and TIMING.
REQ-016 IDLE: a cmd_delay rising edge SHALL load the 8-bit delay_cnt with lfsr + MIN_DELAY and enter DELAY at the same edge.
REQ-017 DELAY, on an en tick with delay_cnt != 0: decrement delay_cnt; without en, hold.
REQ-018 DELAY, on an en tick with delay_cnt == 0: enter TIMING, clear the reaction counter, and assert lights_out for exactly the first TIMING cycle.
REQ-019 TIMING: the reaction counter SHALL increment every clk, ignore en, and saturate at 2^CNT_WIDTH-1.
REQ-020 TIMING: a btn rising edge SHALL load react_time with the current counter value, pulse react_valid, and return to IDLE.
REQ-021 A btn edge in the first TIMING cycle SHALL report react_time = 0.
REQ-022 A cmd_delay edge outside IDLE SHALL be ignored.
REQ-023 In IDLE, a btn edge coinciding with a cmd_delay edge SHALL start DELAY; the btn edge is ignored.
REQ-024 react_time SHALL change only on react_valid cycles.

Reset
REQ-025 rst SHALL force: state IDLE, lfsr 7'h01, delay_cnt 0, counter 0, all edge registers 0.
REQ-026 rst SHALL force all outputs low and react_time to 0, including a reset mid-DELAY or mid-TIMING.
REQ-027 rst SHALL take priority over every other input.

Configuration
REQ-028 Macro F1_FALSE_START_EN, when defined: a btn edge in DELAY SHALL pulse false_start and react_valid, load react_time with all ones, and return to IDLE.
REQ-029 Without F1_FALSE_START_EN: btn SHALL be ignored in DELAY and false_start tied to 0.

Verification
REQ-030 Reset; cmd_delay high in the first cycle after reset, en held high -> delay_cnt loads 9; lights_out pulses on the 10th en tick; busy is high throughout.
REQ-031 After lights_out, btn rises 37 clk later -> react_time = 37 and one react_valid pulse; busy falls the next cycle.
REQ-032 CNT_WIDTH = 4, btn withheld 40 cycles in TIMING, then pressed -> react_time = 15.
REQ-033 F1_FALSE_START_EN defined, btn pressed in DELAY -> false_start and react_valid pulse, react_time = all ones, state IDLE.
REQ-034 F1_FALSE_START_EN undefined, btn pressed in DELAY -> no output change, and lights_out still occurs on schedule.
REQ-035 rst asserted mid-TIMING -> next cycle all outputs 0, react_time = 0, IDLE; a new cmd_delay edge restarts normally.
